rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
Parametrised N-channel arbitrated multiplexer with valid/ready handshakes and a registered output stage.
- Generalises the fixed 8:1 combinational mux to NUM_CH inputs and DATA_WIDTH bits.
- Adds arbitration (round-robin or fixed priority) and one output register with backpressure.
- Sits between multiple requesters, e.g. bus masters or load/store sources, and one shared downstream consumer in the MCU datapath.

Parameters:
DATA_WIDTH, 32, width of each data channel in bits
NUM_CH, 8, number of input channels; >=2, non-power-of-2 allowed
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
CH_W, $clog2(NUM_CH), width of channel index (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i
in_data  input  NUM_CH*DATA_WIDTH  flat bus; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  output  NUM_CH  per-channel accept; at most one bit high per cycle
out_valid  output  1  output register holds a valid beat
out_data  output  DATA_WIDTH  registered data of the accepted beat
out_ch  output  CH_W  index of the channel that supplied out_data
out_ready  input  1  downstream accepts the beat when high together with out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (rst high at a clk edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
- in_ready is combinational and is 0 while rst is high.
- Load enable: load_en = !out_valid || out_ready (combinational).
  - The output register can accept a new beat when it is empty or is being drained this cycle.
- Grant, combinational:
  - ARB_MODE=0: the first i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1.
  - ARB_MODE=1: the lowest i with in_valid[i]=1; ptr is unused and held at 0.
  - in_ready[i] = load_en && grant[i]. in_ready never depends on in_data.
  - in_ready does depend combinationally on out_ready and in_valid. This path is documented and intentional.
- Transfer on channel g (in_valid[g] && in_ready[g] at the edge):
  - out_data <= in_data slice g; out_ch <= g; out_valid <= 1.
  - In RR mode, ptr <= (g==NUM_CH-1) ? 0 : g+1. Wrap-around is explicit, so non-power-of-2 NUM_CH is correct.
- load_en=1 with no in_valid: out_valid <= 0. out_data and out_ch hold their last values (don't-care).
- load_en=0 (out_valid && !out_ready): out_valid, out_data, out_ch and ptr all hold. All in_ready=0.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle when out_ready is held high.
- Simultaneous drain and fill (out_valid && out_ready && some in_valid): the new beat replaces the old one in the same edge with no bubble.
- Stability: out_data and out_ch must not change while out_valid=1 and out_ready=0.
- Requester rule, not checked by the block: a requester keeps in_valid high and in_data stable until accepted.
  - If a requester drops in_valid before it is granted, it is simply not granted. No hang.
- Fairness (RR mode): with all channels continuously requesting, each channel is granted exactly once in any NUM_CH consecutive transfers.
- Reset mid-operation: a beat held in the output register is discarded (out_valid=0 on the next cycle) and ptr returns to 0. A beat offered on the reset cycle is not accepted.
- Widths: all index arithmetic is CH_W bits. No truncation of in_data slices.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=8'hFF -> in_ready=0, out_valid=0, out_data=0, out_ch=0. First grant after reset is channel 0.
- RR fairness (NUM_CH=8, ARB_MODE=0): all in_valid=1, in_data slice i = 32'hA000_0000+i, out_ready=1 for 16 cycles -> out_ch sequence 0..7,0..7; out_data matches; out_valid stays 1 with no bubbles.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 with out_ch=3 -> out_data and out_ch stable, in_ready=0. Raise out_ready -> next beat is channel 4 on the following edge.
- Sparse and wrap: only in_valid[6] and in_valid[1], ptr=7 -> grant 1 then 6, then 1 again. No grant to idle channels.
- Fixed priority (ARB_MODE=1): in_valid[2] and in_valid[5] held high -> channel 2 granted every cycle and channel 5 starved. Drop in_valid[2] -> channel 5 granted next.
- Non-power-of-2 and reset mid-flight (NUM_CH=5): all requesting -> out_ch 0,1,2,3,4,0. Assert rst while out_valid=1 -> out_valid=0 next cycle and the sequence restarts at 0.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N requesters and one shared consumer of rr_arb_mux.
// The slave modport is the arbiter's view; master is the environment's view.
interface rr_arb_mux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_ready;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]              out_ch;
  logic                         out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux: round-robin or fixed-priority grant feeding a
// single registered output stage with valid/ready backpressure.
module rr_arb_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 8,
  parameter int ARB_MODE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_mux_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int IW   = CH_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]       out_ch_q,    out_ch_d;
  logic [CH_W-1:0]       ptr_q,       ptr_d;

  logic                  load_en;
  logic                  grant_found;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       search_base;

  assign load_en     = !out_valid_q || bus.out_ready;
  assign search_base = (ARB_MODE == 1) ? '0 : ptr_q;

  // Circular search from search_base; the explicit wrap keeps non-power-of-2
  // channel counts from aliasing onto nonexistent channels.
  always_comb begin : arbiter
    logic [IW-1:0] cand;
    // NOTE: every comb output gets a default first so no path infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      cand = {1'b0, search_base} + IW'(j);
      if (cand >= IW'(NUM_CH)) cand = cand - IW'(NUM_CH);
      if (!grant_found && bus.in_valid[cand[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign bus.in_ready = (!rst && load_en && grant_found) ?
                        (NUM_CH'(1) << grant_idx) : '0;

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = bus.in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        out_ch_d   = grant_idx;
        if (ARB_MODE == 0) begin
          ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples the pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.in_ready));

  a_ready_needs_valid: assert property (@(posedge clk)
    (bus.in_ready & ~bus.in_valid) == '0);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      ($stable(bus.out_data) && $stable(bus.out_ch) && bus.out_valid));
endmodule

// File: tb/tb_rr_arb_mux.sv
// Drives three arbiter configurations (RR/8, fixed/8, RR/5) from one stimulus
// stream and compares each against a queue-free arithmetic reference model.
module tb_rr_arb_mux;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [7:0]      vld;
  logic [7:0][31:0] dat;
  logic            ordy;

  rr_arb_mux_if #(.DATA_WIDTH(DW), .NUM_CH(8)) if_rr8 ();
  rr_arb_mux_if #(.DATA_WIDTH(DW), .NUM_CH(8)) if_fp8 ();
  rr_arb_mux_if #(.DATA_WIDTH(DW), .NUM_CH(5)) if_rr5 ();

  assign if_rr8.in_valid  = vld;
  assign if_rr8.in_data   = dat;
  assign if_rr8.out_ready = ordy;
  assign if_fp8.in_valid  = vld;
  assign if_fp8.in_data   = dat;
  assign if_fp8.out_ready = ordy;
  assign if_rr5.in_valid  = vld[4:0];
  assign if_rr5.in_data   = dat[4:0];
  assign if_rr5.out_ready = ordy;

  rr_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(8), .ARB_MODE(0)) u_rr8 (
    .clk(clk), .rst(rst), .bus(if_rr8.slave));
  rr_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(8), .ARB_MODE(1)) u_fp8 (
    .clk(clk), .rst(rst), .bus(if_fp8.slave));
  rr_arb_mux #(.DATA_WIDTH(DW), .NUM_CH(5), .ARB_MODE(0)) u_rr5 (
    .clk(clk), .rst(rst), .bus(if_rr5.slave));

  logic [7:0]  obs_rdy [3];
  logic        obs_v   [3];
  logic [31:0] obs_d   [3];
  logic [2:0]  obs_c   [3];

  assign obs_rdy[0] = if_rr8.in_ready;
  assign obs_rdy[1] = if_fp8.in_ready;
  assign obs_rdy[2] = {3'b000, if_rr5.in_ready};
  assign obs_v[0]   = if_rr8.out_valid;
  assign obs_v[1]   = if_fp8.out_valid;
  assign obs_v[2]   = if_rr5.out_valid;
  assign obs_d[0]   = if_rr8.out_data;
  assign obs_d[1]   = if_fp8.out_data;
  assign obs_d[2]   = if_rr5.out_data;
  assign obs_c[0]   = if_rr8.out_ch;
  assign obs_c[1]   = if_fp8.out_ch;
  assign obs_c[2]   = if_rr5.out_ch;

  typedef struct {
    bit        v;
    bit [31:0] d;
    int        c;
    int        ptr;
  } mstate_t;

  mstate_t  m [3];
  const int n_ch [3] = '{8, 8, 5};
  const int mode [3] = '{0, 1, 0};

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Who the spec's rules say wins this cycle; -1 when nobody is accepted.
  function automatic int model_grant(input int k);
    int start;
    if (rst) return -1;
    if (m[k].v && !ordy) return -1;
    start = (mode[k] == 1) ? 0 : m[k].ptr;
    for (int j = 0; j < n_ch[k]; j++) begin
      int idx;
      idx = (start + j) % n_ch[k];
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic [7:0] v, input logic o);
    int g [3];
    rst  = r;
    vld  = v;
    ordy = o;
    #1;
    for (int k = 0; k < 3; k++) begin
      g[k] = model_grant(k);
      check($sformatf("in_ready[u%0d]", k), 64'(obs_rdy[k]),
            (g[k] >= 0) ? (64'd1 << g[k]) : 64'd0);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m[k] = '{v: 1'b0, d: 32'd0, c: 0, ptr: 0};
      end else if (!m[k].v || o) begin
        if (g[k] >= 0) begin
          m[k].v = 1'b1;
          m[k].d = dat[g[k]];
          m[k].c = g[k];
          if (mode[k] == 0) m[k].ptr = (g[k] + 1) % n_ch[k];
        end else begin
          m[k].v = 1'b0;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_valid[u%0d]", k), 64'(obs_v[k]), 64'(m[k].v));
      check($sformatf("out_data[u%0d]", k),  64'(obs_d[k]), 64'(m[k].d));
      check($sformatf("out_ch[u%0d]", k),    64'(obs_c[k]), 64'(m[k].c));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) m[k] = '{v: 1'b0, d: 32'd0, c: 0, ptr: 0};
    rst  = 1'b1;
    vld  = 8'hFF;
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) dat[i] = 32'hA000_0000 + 32'(i);
    @(negedge clk);

    // Reset held with every channel requesting.
    repeat (2) cycle(1'b1, 8'hFF, 1'b1);

    // Fairness: two full rounds with a saturated request vector.
    repeat (16) cycle(1'b0, 8'hFF, 1'b1);

    // Backpressure while holding channel 3, then release.
    repeat (4) cycle(1'b0, 8'hFF, 1'b1);
    check("bp_hold_ch", 64'(obs_c[0]), 64'd3);
    repeat (5) cycle(1'b0, 8'hFF, 1'b0);
    cycle(1'b0, 8'hFF, 1'b1);
    check("bp_release_ch", 64'(obs_c[0]), 64'd4);

    // Advance the 8-channel RR pointer to 7, then sparse requests 1 and 6.
    for (int i = 0; i < 8 && m[0].ptr != 7; i++) cycle(1'b0, 8'hFF, 1'b1);
    check("ptr_reached_7", 64'(m[0].ptr), 64'd7);
    repeat (4) cycle(1'b0, 8'h42, 1'b1);

    // Fixed-priority starvation and hand-over.
    repeat (4) cycle(1'b0, 8'h24, 1'b1);
    repeat (2) cycle(1'b0, 8'h20, 1'b1);

    // Reset mid-flight with a beat in the output register.
    repeat (3) cycle(1'b0, 8'hFF, 1'b1);
    cycle(1'b1, 8'hFF, 1'b1);
    repeat (6) cycle(1'b0, 8'hFF, 1'b1);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 8; c++) dat[c] = $urandom;
      cycle(($urandom_range(0, 63) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
